// File: rtl/jk_counter_pkg.sv
// Shared JK excitation codes and the helper that turns a (present, next) bit
// pair into the J/K inputs a JK cell needs to reach that next value.
package jk_counter_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    typedef struct packed {
        logic j;
        logic k;
    } jk_t;

    // Only SET, RESET or HOLD is ever produced; TOGGLE is left unused on purpose.
    function automatic jk_t jk_excite(input logic q, input logic n);
        jk_t r;
        r.j = ~q & n;
        r.k = q & ~n;
        return r;
    endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control and status bundle of one jk_mod_counter digit.
interface jk_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             En;
    logic             Up;
    logic             Load;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Q_bar;
    logic             TC;
    logic             Co;
    logic             LoadErr;

    modport master (
        output En, Up, Load, D,
        input  Q, Q_bar, TC, Co, LoadErr
    );

    modport slave (
        input  En, Up, Load, D,
        output Q, Q_bar, TC, Co, LoadErr
    );
endinterface

// File: rtl/jk_stage.sv
// Single-bit JK storage cell, falling-edge clocked, async active-high reset
// to q=0 / q_bar=1.
module jk_stage
    import jk_counter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    // NOTE: state registers use non-blocking (<=) so every stage samples the
    // pre-edge value of its neighbours, whatever the process evaluation order.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            unique case ({j, k})
                JK_HOLD:   q <= q;
                JK_RESET:  q <= 1'b0;
                JK_SET:    q <= 1'b1;
                JK_TOGGLE: q <= ~q;
                default:   q <= q;
            endcase
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter with load, built from WIDTH jk_stage cells
// fed by per-bit excitation logic; TC/Co cascade digit to digit.
module jk_mod_counter
    import jk_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    jk_mod_counter_if.slave  bus
);

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $error("jk_mod_counter: WIDTH must be in 1..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("jk_mod_counter: MODULUS must be in 2..2**WIDTH");
    end

    // One extra bit so MODULUS == 2**WIDTH is still representable.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bar;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic             d_ok;
    logic             at_max;
    logic             at_zero;
    logic             tc;
    logic             co;
    logic             load_err;

    always_comb begin
        d_ok    = {1'b0, bus.D} < MOD_EXT;
        at_max  = (q == Q_MAX);
        at_zero = (q == '0);
        // NOTE: n defaults to q before any branch so every path assigns it and
        // no latch is inferred.
        n = q;
        if (bus.Load) begin
            if (d_ok) n = bus.D;
        end else if (bus.En) begin
            if (bus.Up) n = at_max  ? '0    : q + 1'b1;
            else        n = at_zero ? Q_MAX : q - 1'b1;
        end
    end

    assign tc = bus.En & ~bus.Load & (bus.Up ? at_max : at_zero);

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        assign {j_vec[i], k_vec[i]} = jk_excite(q[i], n[i]);

        jk_stage u_stage (
            .clk   (Clk),
            .reset (Reset),
            .j     (j_vec[i]),
            .k     (k_vec[i]),
            .q     (q[i]),
            .q_bar (q_bar[i])
        );
    end

    always_ff @(negedge Clk or posedge Reset) begin
        if (Reset) begin
            co       <= 1'b0;
            load_err <= 1'b0;
        end else begin
            co       <= tc;
            load_err <= bus.Load & ~d_ok;
        end
    end

    assign bus.Q       = q;
    assign bus.Q_bar   = q_bar;
    assign bus.TC      = tc;
    assign bus.Co      = co;
    assign bus.LoadErr = load_err;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Randomized and directed bench for jk_mod_counter: a decade counter against an
// integer modular-arithmetic model, a two-digit BCD cascade and a modulo-16 unit.
module tb_jk_mod_counter;

    localparam int M = 10;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;

    always #5 Clk = ~Clk;

    jk_mod_counter_if #(.WIDTH(4)) if_dec ();
    jk_mod_counter_if #(.WIDTH(4)) if_c0  ();
    jk_mod_counter_if #(.WIDTH(4)) if_c1  ();
    jk_mod_counter_if #(.WIDTH(4)) if_hex ();

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_dec (.Clk(Clk), .Reset(Reset), .bus(if_dec));
    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_c0  (.Clk(Clk), .Reset(Reset), .bus(if_c0));
    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_c1  (.Clk(Clk), .Reset(Reset), .bus(if_c1));
    jk_mod_counter #(.WIDTH(4), .MODULUS(16)) u_hex (.Clk(Clk), .Reset(Reset), .bus(if_hex));

    // Cascade: the ones digit's terminal count enables the tens digit.
    assign if_c1.En = if_c0.TC;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state of the decade counter.
    int mq;
    bit mco;
    bit mle;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("q",       32'(if_dec.Q),       32'(mq));
        check("q_bar",   32'(if_dec.Q_bar),   32'(~mq & 15));
        check("co",      32'(if_dec.Co),      32'(mco));
        check("load_err", 32'(if_dec.LoadErr), 32'(mle));
    endtask

    // Apply one set of inputs for one falling edge and check before/after it.
    task automatic step(input bit en, input bit up, input bit load, input int d);
        int nq;
        bit tc;
        if_dec.En   = en;
        if_dec.Up   = up;
        if_dec.Load = load;
        if_dec.D    = 4'(d);
        if (load)    nq = (d < M) ? d : mq;
        else if (en) nq = up ? (mq + 1) % M : (mq + M - 1) % M;
        else         nq = mq;
        tc = en && !load && (up ? (mq == M - 1) : (mq == 0));
        #1;
        check("tc",    32'(if_dec.TC),    32'(tc));
        check("j_vec", 32'(u_dec.j_vec),  32'(~mq & nq & 15));
        check("k_vec", 32'(u_dec.k_vec),  32'(mq & ~nq & 15));
        @(negedge Clk);
        mco = tc;
        mle = load && (d >= M);
        mq  = nq;
        @(posedge Clk);
        #1;
        check_outputs();
    endtask

    // Assert reset between edges, check the asynchronous clear, optionally hold
    // it across several falling edges, then release after a rising edge.
    task automatic do_reset(input int hold_edges);
        Reset = 1'b1;
        #1;
        mq  = 0;
        mco = 1'b0;
        mle = 1'b0;
        check_outputs();
        for (int i = 0; i < hold_edges; i++) begin
            @(negedge Clk);
            #1;
            check("q_in_reset", 32'(if_dec.Q), 32'd0);
            check("q_bar_in_reset", 32'(if_dec.Q_bar), 32'd15);
        end
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        if_dec.En = 0; if_dec.Up = 1; if_dec.Load = 0; if_dec.D = '0;
        if_c0.En  = 0; if_c0.Up  = 1; if_c0.Load  = 0; if_c0.D  = '0;
        if_c1.Up  = 1; if_c1.Load = 0; if_c1.D = '0;
        if_hex.En = 0; if_hex.Up = 1; if_hex.Load = 0; if_hex.D = '0;
        #1;
        do_reset(0);

        // Count up across the 9 -> 0 wrap.
        repeat (12) step(1, 1, 0, 0);

        // Load 0 then count down across the 0 -> 9 wrap.
        step(0, 0, 1, 0);
        repeat (3) step(1, 0, 0, 0);

        // Load beats enable; an out-of-range load holds and flags one cycle.
        step(1, 1, 1, 7);
        step(0, 1, 1, 12);
        step(0, 1, 0, 0);

        // Hold at 4 with enable low.
        step(0, 1, 1, 4);
        for (int i = 0; i < 5; i++) step(0, i[0], 0, 0);

        // Reset while Co=1, held across three edges with enable high.
        step(0, 1, 1, 9);
        step(1, 1, 0, 0);
        if_dec.En = 1; if_dec.Up = 1;
        do_reset(3);

        // Reset mid-count at 6, and while LoadErr=1.
        step(0, 1, 1, 6);
        do_reset(0);
        step(0, 1, 1, 12);
        do_reset(0);

        // Randomized traffic, including direction changes and bad loads.
        for (int i = 0; i < 300; i++)
            step(($urandom % 4) != 0, $urandom % 2, ($urandom % 5) == 0, int'($urandom % 16));

        // Two-digit BCD cascade and modulo-16 unit, 100 edges from zero.
        if_dec.En = 0; if_dec.Load = 0;
        do_reset(0);
        if_c0.En  = 1;
        if_hex.En = 1;
        pulses = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge Clk);
            @(posedge Clk);
            #1;
            check("bcd_value", 32'(int'(if_c1.Q) * 10 + int'(if_c0.Q)), 32'(k % 100));
            check("bcd_co",    32'(if_c1.Co), 32'((k % 100) == 0));
            check("hex_q",     32'(if_hex.Q), 32'(k % 16));
            check("hex_co",    32'(if_hex.Co), 32'((k % 16) == 0));
            if (if_c1.Co) pulses++;
        end
        check("bcd_co_pulses", 32'(pulses), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
